// File: rtl/lfsr_rng_sched_pkg.sv
// Shared definitions for the LFSR random-word scheduler.
//   state_t        : scheduler FSM states (IDLE, LOAD, WARM, RUN)
//   LOCKUP_PATTERN : all-ones word, the XNOR-LFSR lock-up state; a seed equal
//                    to it (at the LFSR width) is replaced by zero
//   lfsr_taps()    : XNOR feedback tap mask for widths 3..32, bit p-1 set
//                    for tap position p
package lfsr_rng_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WARM = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam logic [31:0] LOCKUP_PATTERN = 32'hFFFF_FFFF;

  function automatic logic [31:0] tap(input int pos);
    return 32'd1 << (pos - 1);
  endfunction

  // Maximal-length XNOR tap sets; every entry has an even tap count so the
  // feedback reduces to the inverted parity of the tapped bits.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      3:       return tap(3)  | tap(2);
      4:       return tap(4)  | tap(3);
      5:       return tap(5)  | tap(3);
      6:       return tap(6)  | tap(5);
      7:       return tap(7)  | tap(6);
      8:       return tap(8)  | tap(6)  | tap(5) | tap(4);
      9:       return tap(9)  | tap(5);
      10:      return tap(10) | tap(7);
      11:      return tap(11) | tap(9);
      12:      return tap(12) | tap(6)  | tap(4) | tap(1);
      13:      return tap(13) | tap(4)  | tap(3) | tap(1);
      14:      return tap(14) | tap(5)  | tap(3) | tap(1);
      15:      return tap(15) | tap(14);
      16:      return tap(16) | tap(15) | tap(13) | tap(4);
      17:      return tap(17) | tap(14);
      18:      return tap(18) | tap(11);
      19:      return tap(19) | tap(6)  | tap(2) | tap(1);
      20:      return tap(20) | tap(17);
      21:      return tap(21) | tap(19);
      22:      return tap(22) | tap(21);
      23:      return tap(23) | tap(18);
      24:      return tap(24) | tap(23) | tap(22) | tap(17);
      25:      return tap(25) | tap(22);
      26:      return tap(26) | tap(6)  | tap(2) | tap(1);
      27:      return tap(27) | tap(5)  | tap(2) | tap(1);
      28:      return tap(28) | tap(25);
      29:      return tap(29) | tap(27);
      30:      return tap(30) | tap(6)  | tap(4) | tap(1);
      31:      return tap(31) | tap(28);
      32:      return tap(32) | tap(22) | tap(2) | tap(1);
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr.sv
// XNOR Fibonacci LFSR datapath.
//   i_Clk, i_Rst     : clock, synchronous active-high reset (state -> 0)
//   i_Enable         : advance (or load) this cycle
//   i_Seed_DV        : with i_Enable, load i_Seed_Data instead of stepping
//   i_Seed_Data      : seed value
//   o_LFSR_Data      : current state
//   o_LFSR_Next      : state after one step (used for wrap detection)
module lfsr
  import lfsr_rng_sched_pkg::*;
#(
  parameter int NUM_BITS = 32
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Next
);

  localparam logic [31:0]         TAPS     = lfsr_taps(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAP_MASK = TAPS[NUM_BITS-1:0];

  logic [NUM_BITS-1:0] lfsr_reg;
  logic                feedback;

  assign feedback    = ~^(lfsr_reg & TAP_MASK);
  assign o_LFSR_Next = {lfsr_reg[NUM_BITS-2:0], feedback};
  assign o_LFSR_Data = lfsr_reg;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      lfsr_reg <= '0;
    end else if (i_Enable) begin
      lfsr_reg <= i_Seed_DV ? i_Seed_Data : o_LFSR_Next;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : highest-priority lane (must be < NUM_REQ)
//   enable : when low, no grant is produced
//   gnt    : one-hot winner (first set bit at or after ptr, cyclic)
//   idx    : index of the winner (meaningful only when gnt != 0)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  // Requests at or above the pointer win over the wrapped-around ones; if
  // none sit there, the lowest request overall is the cyclic successor.
  logic [NUM_REQ-1:0] upper;
  logic [NUM_REQ-1:0] pick;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_upper
    assign upper[gi] = req[gi] && (PTR_W'(gi) >= ptr);
  end

  assign pick = (|upper) ? upper : req;

  always_comb begin
    logic found;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && pick[i]) begin
        found  = 1'b1;
        idx    = PTR_W'(i);
        gnt[i] = enable;
      end
    end
  end

endmodule

// File: rtl/lfsr_rng_sched.sv
// Shares one LFSR among NUM_REQ sampler lanes: seed load, WARMUP discarded
// steps, then round-robin delivery of one fresh word per grant.
//   i_Clk, i_Rst  : clock, synchronous active-high reset
//   i_Seed_DV     : (re)seed pulse, accepted in any state
//   i_Seed_Data   : seed, sampled with i_Seed_DV
//   i_Req         : level request per lane
//   o_Gnt         : registered one-hot grant, valid with o_Rand_Valid
//   o_Rand_Valid  : o_Rand_Data carries a new word this cycle
//   o_Rand_Data   : word for the granted lane (holds when idle)
//   o_Ready       : scheduler is delivering words
//   o_Wrap        : the LFSR has just stepped back onto the loaded seed
module lfsr_rng_sched
  import lfsr_rng_sched_pkg::*;
#(
  parameter int NUM_BITS = 32,
  parameter int NUM_REQ  = 4,
  parameter int WARMUP   = 64
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  input  logic [NUM_REQ-1:0]  i_Req,
  output logic [NUM_REQ-1:0]  o_Gnt,
  output logic                o_Rand_Valid,
  output logic [NUM_BITS-1:0] o_Rand_Data,
  output logic                o_Ready,
  output logic                o_Wrap
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  localparam logic [NUM_BITS-1:0] LOCKUP    = LOCKUP_PATTERN[NUM_BITS-1:0];
  localparam logic [WARM_W-1:0]   WARM_LAST = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(NUM_REQ - 1);

  state_t              state_reg, state_next;
  logic [WARM_W-1:0]   warm_cnt_reg, warm_cnt_next;
  logic [NUM_BITS-1:0] seed_reg;
  logic [NUM_BITS-1:0] seed_sane;
  logic [PTR_W-1:0]    rr_ptr_reg;
  logic [NUM_REQ-1:0]  gnt_reg;
  logic                valid_reg;
  logic [NUM_BITS-1:0] data_reg;
  logic                wrap_reg;

  logic                lfsr_en;
  logic                lfsr_load;
  logic [NUM_BITS-1:0] lfsr_data;
  logic [NUM_BITS-1:0] lfsr_next;

  logic                arb_en;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [PTR_W-1:0]    arb_idx;
  logic                fire;

  // The all-ones seed would freeze the XNOR LFSR; zero is loaded instead and
  // also serves as the wrap reference.
  assign seed_sane = (i_Seed_Data == LOCKUP) ? '0 : i_Seed_Data;

  // A seed pulse cancels the grant that would otherwise issue this cycle.
  assign arb_en = (state_reg == ST_RUN) && !i_Seed_DV;
  assign fire   = |arb_gnt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req    (i_Req),
    .ptr    (rr_ptr_reg),
    .enable (arb_en),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  lfsr #(
    .NUM_BITS (NUM_BITS)
  ) u_lfsr (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Enable    (lfsr_en),
    .i_Seed_DV   (lfsr_load),
    .i_Seed_Data (seed_reg),
    .o_LFSR_Data (lfsr_data),
    .o_LFSR_Next (lfsr_next)
  );

  always_comb begin
    state_next    = state_reg;
    warm_cnt_next = '0;
    lfsr_en       = 1'b0;
    lfsr_load     = 1'b0;
    case (state_reg)
      ST_IDLE: ;
      ST_LOAD: begin
        lfsr_en    = 1'b1;
        lfsr_load  = 1'b1;
        state_next = (WARMUP > 0) ? ST_WARM : ST_RUN;
      end
      ST_WARM: begin
        lfsr_en = 1'b1;
        if (warm_cnt_reg == WARM_LAST) begin
          state_next = ST_RUN;
        end else begin
          warm_cnt_next = warm_cnt_reg + WARM_W'(1);
        end
      end
      ST_RUN: begin
        // Only a granted word consumes an LFSR step.
        lfsr_en = fire;
      end
      default: state_next = ST_IDLE;
    endcase
    if (i_Seed_DV) begin
      state_next    = ST_LOAD;
      warm_cnt_next = '0;
      lfsr_en       = 1'b0;
      lfsr_load     = 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_reg    <= ST_IDLE;
      warm_cnt_reg <= '0;
      seed_reg     <= '0;
      rr_ptr_reg   <= '0;
      gnt_reg      <= '0;
      valid_reg    <= 1'b0;
      data_reg     <= '0;
      wrap_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      warm_cnt_reg <= warm_cnt_next;
      if (i_Seed_DV) begin
        seed_reg <= seed_sane;
      end
      gnt_reg   <= arb_gnt;
      valid_reg <= fire;
      wrap_reg  <= fire && (lfsr_next == seed_reg);
      if (fire) begin
        data_reg   <= lfsr_data;
        rr_ptr_reg <= (arb_idx == PTR_LAST) ? '0 : arb_idx + PTR_W'(1);
      end
    end
  end

  assign o_Gnt        = gnt_reg;
  assign o_Rand_Valid = valid_reg;
  assign o_Rand_Data  = data_reg;
  assign o_Ready      = (state_reg == ST_RUN);
  assign o_Wrap       = wrap_reg;

endmodule

// File: tb/tb_lfsr_rng_sched.sv
// Scoreboard bench for lfsr_rng_sched: a 32-bit/4-lane/WARMUP=64 build and a
// 5-bit/3-lane/WARMUP=0 build run side by side from one stimulus process.
module tb_lfsr_rng_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_sdv, b_sdv;
  logic [31:0] a_seed;
  logic [4:0]  b_seed;
  logic [3:0]  a_req, a_gnt;
  logic [2:0]  b_req, b_gnt;
  logic        a_valid, b_valid, a_ready, b_ready, a_wrap, b_wrap;
  logic [31:0] a_data;
  logic [4:0]  b_data;

  lfsr_rng_sched #(.NUM_BITS(32), .NUM_REQ(4), .WARMUP(64)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Seed_DV(a_sdv), .i_Seed_Data(a_seed),
    .i_Req(a_req), .o_Gnt(a_gnt), .o_Rand_Valid(a_valid),
    .o_Rand_Data(a_data), .o_Ready(a_ready), .o_Wrap(a_wrap)
  );

  lfsr_rng_sched #(.NUM_BITS(5), .NUM_REQ(3), .WARMUP(0)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Seed_DV(b_sdv), .i_Seed_Data(b_seed),
    .i_Req(b_req), .o_Gnt(b_gnt), .o_Rand_Valid(b_valid),
    .o_Rand_Data(b_data), .o_Ready(b_ready), .o_Wrap(b_wrap)
  );

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          due;
    logic [15:0] gnt;
    logic [31:0] data;
    logic        wrap;
  } beat_t;

  beat_t q_a[$];
  beat_t q_b[$];

  // Reference model: per build, cycles left until words flow (-1 = unseeded),
  // the next word to hand out, the wrap reference and the next lane to favour.
  int          nb[2] = '{32, 5};
  int          nr[2] = '{4, 3};
  int          wu[2] = '{64, 0};
  int          until_run[2] = '{-1, -1};
  int          ptr[2] = '{0, 0};
  int          grants[2] = '{0, 0};
  int          wraps_seen[2] = '{0, 0};
  logic [31:0] lval[2];
  logic [31:0] refv[2];

  logic [15:0] req_m[2];
  logic        sdv_m[2];
  logic [31:0] seed_m[2];
  logic        rst_m;

  function automatic logic [31:0] width_mask(input int n);
    return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  // One step of the maximal-length XNOR LFSR: new bit = XNOR chain of taps,
  // shifted in at the bottom.
  function automatic logic [31:0] model_step(input logic [31:0] v, input int n);
    int   t[4];
    int   cnt;
    logic x;
    if (n == 32) begin
      t = '{32, 22, 2, 1};
      cnt = 4;
    end else begin
      t = '{5, 3, 0, 0};
      cnt = 2;
    end
    x = v[t[0]-1];
    for (int k = 1; k < cnt; k++) x = ~(x ^ v[t[k]-1]);
    return ((v << 1) | {31'd0, x}) & width_mask(n);
  endfunction

  function automatic logic [31:0] model_adv(input logic [31:0] v, input int k, input int n);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = model_step(r, n);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, got, exp);
    end
  endtask

  // Monitor side: match each valid beat against the entry due this edge.
  task automatic mon(input int d, input logic valid, input logic [15:0] gnt,
                     input logic [31:0] data, input logic wrap);
    beat_t b;
    bit    have;
    string tag;
    tag  = (d == 0) ? "a" : "b";
    have = 1'b0;
    if (d == 0 && q_a.size() > 0) begin b = q_a[0]; have = (b.due == edge_cnt); end
    if (d == 1 && q_b.size() > 0) begin b = q_b[0]; have = (b.due == edge_cnt); end
    if (valid && wrap) wraps_seen[d]++;
    if (valid && !have) begin
      check({"unexpected_beat_", tag}, 64'(valid), 64'(0));
    end else if (have) begin
      if (valid)
        check({"beat_", tag}, {15'd0, gnt, data, wrap}, {15'd0, b.gnt, b.data, b.wrap});
      else
        check({"missing_beat_", tag}, 64'(valid), 64'(1));
      if (d == 0) void'(q_a.pop_front());
      else        void'(q_b.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_valid, 16'(a_gnt), a_data, a_wrap);
    mon(1, b_valid, 16'(b_gnt), 32'(b_data), b_wrap);
  end

  // One clock of stimulus: check o_Ready, drive inputs, predict the response.
  task automatic tick();
    beat_t       e;
    int          w;
    int          c;
    logic [31:0] nxt;
    logic [31:0] s;
    check("ready_a", 64'(a_ready), 64'(until_run[0] == 0));
    check("ready_b", 64'(b_ready), 64'(until_run[1] == 0));
    rst    = rst_m;
    a_sdv  = sdv_m[0];
    a_seed = seed_m[0];
    a_req  = req_m[0][3:0];
    b_sdv  = sdv_m[1];
    b_seed = seed_m[1][4:0];
    b_req  = req_m[1][2:0];
    for (int d = 0; d < 2; d++) begin
      if (rst_m) begin
        until_run[d] = -1;
        ptr[d]       = 0;
      end else if (sdv_m[d]) begin
        s            = seed_m[d] & width_mask(nb[d]);
        refv[d]      = (s == width_mask(nb[d])) ? 32'd0 : s;
        lval[d]      = model_adv(refv[d], wu[d], nb[d]);
        grants[d]    = 0;
        until_run[d] = 2 + wu[d];
      end else if (until_run[d] == 0 && (req_m[d] & width_mask(nr[d])) != 0) begin
        w = -1;
        for (int i = 0; i < nr[d]; i++) begin
          c = (ptr[d] + i) % nr[d];
          if (w < 0 && req_m[d][c]) w = c;
        end
        nxt    = model_step(lval[d], nb[d]);
        e.due  = edge_cnt + 1;
        e.gnt  = 16'd1 << w;
        e.data = lval[d];
        e.wrap = (nxt == refv[d]);
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
        lval[d] = nxt;
        ptr[d]  = (w + 1) % nr[d];
        grants[d]++;
      end
      if (until_run[d] > 0) until_run[d]--;
    end
    @(posedge clk);
    #1;
    sdv_m[0] = 1'b0;
    sdv_m[1] = 1'b0;
    rst_m    = 1'b0;
  endtask

  task automatic check_zero();
    check("rst_out_a", {a_gnt, a_valid, a_data, a_ready, a_wrap}, 64'd0);
    check("rst_out_b", {b_gnt, b_valid, b_data, b_ready, b_wrap}, 64'd0);
  endtask

  int ws;

  initial begin
    rst = 1'b1;
    a_sdv = 1'b0; b_sdv = 1'b0; a_seed = '0; b_seed = '0; a_req = '0; b_req = '0;
    req_m  = '{16'd0, 16'd0};
    sdv_m  = '{1'b0, 1'b0};
    seed_m = '{32'd0, 32'd0};
    repeat (2) @(posedge clk);
    #1;
    rst_m = 1'b1;
    tick();
    check_zero();

    // Seed both builds; lane 0 held on each.
    seed_m[0] = 32'h1;  sdv_m[0] = 1'b1; req_m[0] = 16'h1;
    seed_m[1] = 32'h01; sdv_m[1] = 1'b1; req_m[1] = 16'h1;
    tick();
    repeat (96) tick();
    req_m[1] = 16'h0;
    tick();
    check("wrap_count_b", 64'(wraps_seen[1]), 64'(grants[1] / 31));

    // All lanes requesting, then alternate pairs.
    req_m[0] = 16'hF; req_m[1] = 16'h5;
    repeat (12) tick();
    req_m[0] = 16'hA;
    for (int i = 0; i < 8; i++) begin
      req_m[1] = 16'($urandom_range(0, 7));
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      req_m[0] = 16'($urandom_range(0, 15));
      req_m[1] = 16'($urandom_range(0, 7));
      tick();
    end

    // Reseed during RUN; b gets the lock-up seed.
    req_m[0] = 16'hF; seed_m[0] = 32'hDEAD_BEEF; sdv_m[0] = 1'b1;
    req_m[1] = 16'h2; seed_m[1] = 32'h1F;        sdv_m[1] = 1'b1;
    tick();
    ws = wraps_seen[1];
    for (int i = 0; i < 80; i++) begin
      req_m[0] = 16'($urandom_range(1, 15));
      tick();
    end
    req_m[1] = 16'h0;
    tick();
    check("wrap_count_b_zero_seed", 64'(wraps_seen[1] - ws), 64'(grants[1] / 31));

    // Reset during WARM (a) / RUN (b) with requests active.
    req_m[0] = 16'hF; req_m[1] = 16'h7;
    seed_m[0] = $urandom; sdv_m[0] = 1'b1;
    seed_m[1] = $urandom; sdv_m[1] = 1'b1;
    tick();
    repeat (20) tick();
    rst_m = 1'b1;
    tick();
    check_zero();
    repeat (8) tick();

    // Reset during RUN on both.
    seed_m[0] = $urandom; sdv_m[0] = 1'b1;
    seed_m[1] = $urandom; sdv_m[1] = 1'b1;
    tick();
    for (int i = 0; i < 70; i++) begin
      req_m[0] = 16'($urandom_range(1, 15));
      req_m[1] = 16'($urandom_range(1, 7));
      tick();
    end
    rst_m = 1'b1;
    tick();
    check_zero();
    req_m[0] = 16'h0; req_m[1] = 16'h0;
    repeat (3) tick();

    check("drain_a", 64'(q_a.size()), 64'd0);
    check("drain_b", 64'(q_b.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
